// File: rtl/vga_frame_fetcher_pkg.sv
// Shared SRAM-port types and framebuffer geometry for the VGA frame fetcher.
// SRAM widths match the arbiter's 1M x 16 external part.
package vga_frame_fetcher_pkg;

  localparam int SRAM_ADDRESS_WIDTH  = 20;
  localparam int SRAM_DATA_WIDTH     = 16;
  localparam int FRAME_WORDS_DEFAULT = 307200;
  localparam int FB_BASE_ADDR        = 0;

  typedef struct packed {
    logic [SRAM_ADDRESS_WIDTH-1:0] address;
    logic                          oe_n;
    logic                          we_n;
    logic                          den;
    logic [SRAM_DATA_WIDTH-1:0]    dout;
  } SramRequest_t;

  typedef struct packed {
    logic                       done;
    logic [SRAM_DATA_WIDTH-1:0] din;
  } SramResult_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAINED
  } FetcherState_t;

endpackage

// File: rtl/vga_frame_fetcher_fifo.sv
// First-word-fall-through FIFO: head is combinational, push lands one cycle later.
// Push while full is accepted only together with a pop; flush empties it in one cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPop;
  logic             doPush;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  // Storage is cleared on reset so the head reads zero before the first frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_frame_fetcher.sv
// Streams one framebuffer per frameStart from SRAM into a small FWFT FIFO for scanout.
// First pixel 2-3 cycles after frameStart; a full FIFO simply skips the granted slot.
module vga_frame_fetcher
  import vga_frame_fetcher_pkg::*;
#(
  parameter int BASE_ADDR   = FB_BASE_ADDR,
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frameStart,
  input  logic                       pixelReq,
  output logic [SRAM_DATA_WIDTH-1:0] pixelData,
  output logic                       pixelValid,
  output logic                       underflow,
  output SramRequest_t               vgaRequest,
  input  SramResult_t                vgaResult
);

  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SRAM_ADDRESS_WIDTH-1:0] BASE      = SRAM_ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]                 LAST_WORD = CW'(FRAME_WORDS - 1);

  FetcherState_t                 state;
  FetcherState_t                 stateNext;
  logic [SRAM_ADDRESS_WIDTH-1:0] readAddr;
  logic [CW-1:0]                 fetchCount;
  logic [QW-1:0]                 fifoCount;
  logic                          fifoFull;
  logic                          fifoEmpty;
  logic                          pop;
  logic                          capture;

  assign pop        = pixelReq && !fifoEmpty;
  assign pixelValid = (fifoCount != '0);
  // A same-cycle pop frees the slot, so a full FIFO can still take the granted word.
  assign capture    = (state == FETCH) && vgaResult.done && (!fifoFull || pop) && !frameStart;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext             = state;
    vgaRequest.address    = readAddr;
    vgaRequest.oe_n       = 1'b1;
    vgaRequest.we_n       = 1'b1;
    vgaRequest.den        = 1'b0;
    vgaRequest.dout       = '0;
    if (frameStart) begin
      stateNext = FETCH;
    end else begin
      case (state)
        IDLE:    stateNext = IDLE;
        FETCH:   if (capture && fetchCount == LAST_WORD) stateNext = DRAINED;
        DRAINED: stateNext = DRAINED;
        default: stateNext = IDLE;
      endcase
    end
    if (state == FETCH) vgaRequest.oe_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || frameStart) begin
      readAddr   <= BASE;
      fetchCount <= '0;
    end else if (capture) begin
      readAddr   <= readAddr + 1'b1;
      fetchCount <= fetchCount + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                           underflow <= 1'b0;
    else if (pixelReq && fifoEmpty && !frameStart)     underflow <= 1'b1;
  end

  sync_fifo_fwft #(
    .WIDTH (SRAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (frameStart),
    .push     (capture),
    .pushData (vgaResult.din),
    .pop      (pop),
    .head     (pixelData),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// Scoreboarded bench: a full-size frame fetcher and a 16-word-frame instance share one SRAM model.
module tb_vga_frame_fetcher;
  import vga_frame_fetcher_pkg::*;

  localparam int DW = SRAM_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fsM = 1'b0, prM = 1'b0, fsS = 1'b0, prS = 1'b0;
  logic done = 1'b0, doneOn = 1'b0, useSmall = 1'b0;
  logic [DW-1:0] dataM, dataS;
  logic validM, validS, uflowM, uflowS;
  SramRequest_t reqM, reqS;
  SramResult_t  resM, resS;

  int checks = 0;
  int errors = 0;
  int popsM  = 0;
  logic [DW-1:0] expQM[$];
  logic [DW-1:0] expQS[$];

  always #5 clk = ~clk;

  // SRAM model: every word reads back as its address plus 0x100.
  assign resM.done = done;
  assign resM.din  = reqM.address[DW-1:0] + 16'h100;
  assign resS.done = done;
  assign resS.din  = reqS.address[DW-1:0] + 16'h100;

  vga_frame_fetcher u_main (
    .clk(clk), .rst(rst), .frameStart(fsM), .pixelReq(prM),
    .pixelData(dataM), .pixelValid(validM), .underflow(uflowM),
    .vgaRequest(reqM), .vgaResult(resM)
  );

  vga_frame_fetcher #(.FRAME_WORDS(16)) u_small (
    .clk(clk), .rst(rst), .frameStart(fsS), .pixelReq(prS),
    .pixelData(dataS), .pixelValid(validS), .underflow(uflowS),
    .vgaRequest(reqS), .vgaResult(resS)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic fs, input logic pr);
    @(posedge clk);
    #1;
    fsM  = useSmall ? 1'b0 : fs;
    prM  = useSmall ? 1'b0 : pr;
    fsS  = useSmall ? fs : 1'b0;
    prS  = useSmall ? pr : 1'b0;
    done = doneOn ? ~done : 1'b0;
  endtask

  // Monitors: a pop happens at the next edge, so compare the head now.
  always @(negedge clk) begin
    if (!rst && prM && validM && !fsM) begin
      popsM++;
      if (expQM.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mainPix actual=%0h required=none", dataM);
      end else begin
        check("mainPix", {16'h0, dataM}, {16'h0, expQM.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && prS && validS && !fsS) begin
      if (expQS.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL smallPix actual=%0h required=none", dataS);
      end else begin
        check("smallPix", {16'h0, dataS}, {16'h0, expQS.pop_front()});
      end
    end
  end

  initial begin
    doneOn = 1'b1;
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;

    // Reset and idle
    @(negedge clk);
    check("rstOeN",   reqM.oe_n, 1);
    check("rstWeN",   reqM.we_n, 1);
    check("rstDen",   reqM.den, 0);
    check("rstAddr",  reqM.address, 0);
    check("rstValid", validM, 0);
    check("rstData",  dataM, 0);
    check("rstUflow", uflowM, 0);
    check("smallRstOeN", reqS.oe_n, 1);
    repeat (8) tick(0, 0);
    @(negedge clk);
    check("idleAddr",  reqM.address, 0);
    check("idleOeN",   reqM.oe_n, 1);
    check("idleValid", validM, 0);

    // Frame fill with no pops
    expQM.delete();
    for (int i = 0; i < 1100; i++) expQM.push_back(DW'(16'h100 + i));
    tick(1, 0);
    repeat (24) tick(0, 0);
    @(negedge clk);
    check("fillAddr",  reqM.address, 8);
    check("fillHead",  dataM, 16'h100);
    check("fillValid", validM, 1);
    check("fillOeN",   reqM.oe_n, 0);

    // Steady scan, one pop every other cycle
    popsM = 0;
    for (int i = 0; i < 2000; i++) tick(0, (i % 2) == 0);
    repeat (6) tick(0, 0);
    @(negedge clk);
    check("scanPops",  popsM, 1000);
    check("scanUflow", uflowM, 0);
    check("fullAddr",  reqM.address, 1008);

    // Full FIFO: grant and pop in the same cycle
    if (done) tick(0, 0);
    tick(0, 1);
    tick(0, 0);
    @(negedge clk);
    check("pushPopAddr",  reqM.address, 1009);
    check("pushPopValid", validM, 1);
    repeat (6) tick(0, 0);
    @(negedge clk);
    check("stillFullAddr", reqM.address, 1009);
    repeat (8) tick(0, 1);
    tick(0, 0);

    // frameStart mid-frame with a grant and a pop pending
    if (done) tick(0, 0);
    expQM.delete();
    for (int i = 0; i < 16; i++) expQM.push_back(DW'(16'h100 + i));
    tick(1, 1);
    tick(0, 0);
    @(negedge clk);
    check("fsValid", validM, 0);
    check("fsAddr",  reqM.address, 0);
    check("fsOeN",   reqM.oe_n, 0);
    repeat (6) tick(0, 0);
    @(negedge clk);
    check("fsHead", dataM, 16'h100);
    repeat (3) tick(0, 1);
    tick(0, 0);
    @(negedge clk);
    check("mainUflow", uflowM, 0);

    // Frame end on the 16-word instance
    useSmall = 1'b1;
    for (int i = 0; i < 16; i++) expQS.push_back(DW'(16'h100 + i));
    tick(1, 0);
    repeat (10) tick(0, 0);
    for (int k = 1; k <= 17; k++) begin
      tick(0, 1);
      tick(0, 0);
      @(negedge clk);
      check("smallUflow", uflowS, (k == 17));
    end
    check("smallOeN",   reqS.oe_n, 1);
    check("smallAddr",  reqS.address, 16);
    check("smallValid", validS, 0);
    check("smallLeft",  expQS.size(), 0);
    tick(1, 0);
    repeat (4) tick(0, 0);
    @(negedge clk);
    check("uflowSticky", uflowS, 1);
    check("refetchOeN",  reqS.oe_n, 0);

    // Reset mid-frame
    rst = 1'b1;
    tick(0, 0);
    tick(0, 0);
    @(negedge clk);
    check("midRstValid", validM, 0);
    check("midRstAddr",  reqM.address, 0);
    check("midRstOeN",   reqM.oe_n, 1);
    check("midRstData",  dataM, 0);
    check("midRstUflow", uflowS, 0);
    rst = 1'b0;
    repeat (4) tick(0, 0);
    @(negedge clk);
    check("postRstAddr", reqS.address, 0);
    check("postRstOeN",  reqS.oe_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_fetcher.md
Name: vga_frame_fetcher

Overview:
- Read-side client of the SRAM arbiter's VGA slot.
- On each frame start, walks the framebuffer sequentially from BASE_ADDR, issues one read per granted VGA slot (`vgaResult.done`), and buffers returned words in a small first-word-fall-through FIFO.
- The downstream VGA timing/scanout logic pops one word per visible pixel.
- Decouples the arbiter's 1-in-2-cycle read slot from the scanout pixel pace.

Parameters:
- BASE_ADDR, 0, first SRAM word address of the framebuffer.
- FRAME_WORDS, 307200, words per frame (640x480, one word per pixel).
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  system clock, same 25 MHz domain as the SRAM arbiter.
- rst  in  1  synchronous reset, active-high.
- frameStart  in  1  one-cycle pulse before the first visible pixel of a frame.
- pixelReq  in  1  scanout consumes the FIFO head this cycle.
- pixelData  out  `SRAM_DATA_WIDTH`  FIFO head word.
- pixelValid  out  1  FIFO non-empty.
- underflow  out  1  sticky: a pop was attempted while the FIFO was empty.
- vgaRequest  out  SramRequest_t  address/oe_n/we_n/den/dout to the arbiter's VGA slot.
- vgaResult  in  SramResult_t  done (slot granted this cycle) and din (read data, valid in the same cycle as done).

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high; all state updates on posedge `clk`.

- Reset values:
  - state=IDLE, readAddr=BASE_ADDR, fetchCount=0, FIFO count=0.
  - pixelValid=0, pixelData=0, underflow=0.
  - vgaRequest: address=BASE_ADDR, oe_n=1, we_n=1, den=0, dout=0.

- Constant request fields in all states: we_n=1, den=0, dout=0. This block never writes.
- Address field: vgaRequest.address=readAddr in all states.

- State machine:
  - IDLE: oe_n=1. frameStart -> FETCH.
  - FETCH: oe_n=0.
    - Capture condition: vgaResult.done && (count<FIFO_DEPTH || pop).
    - On capture: push vgaResult.din, readAddr+=1, fetchCount+=1.
    - Capture of word FRAME_WORDS-1 -> DRAINED.
  - DRAINED: oe_n=1. No further captures. frameStart -> FETCH.

- frameStart in any state, highest priority:
  - FIFO flushed (count=0), readAddr=BASE_ADDR, fetchCount=0, state=FETCH.
  - Any same-cycle capture or pop is discarded.
  - pixelValid=0 in the next cycle.

- Address arithmetic: readAddr is `SRAM_ADDRESS_WIDTH` bits and never wraps inside a frame. fetchCount is $clog2(FRAME_WORDS+1) bits.

- FIFO:
  - First-word-fall-through. pixelData shows the head combinationally; pixelValid = (count!=0).
  - pop = pixelReq && count!=0.
  - Push and pop may occur in the same cycle, including when full, if the capture condition holds; count is then unchanged.
  - Push when full without a pop does not occur, because capture is gated.
  - The arbiter slot is simply skipped when full; no data is lost because nothing is captured.

- Underflow: pixelReq && count==0 (and no frameStart) sets underflow=1.
  - The FIFO is unchanged and pixelData holds its value.
  - underflow is cleared only by rst.

- Latency:
  - frameStart at cycle T -> the first capture is at the first done cycle >= T+1 -> pixelValid=1 the cycle after that capture.
  - With the arbiter alternating, pixelValid rises at T+2 or T+3.

- Throughput: at most one word per 2 cycles. The scanout must average no more than one pop per 2 cycles, which holds for a 25 MHz clock with a 12.5 MHz-equivalent pixel pace or line blanking. Violations show up as underflow.

- Reset mid-frame: everything returns to reset values and the next frameStart is required before fetching resumes.

Decomposition:
- Shared package (DataType.sv):
  - Add `FRAME_WORDS` and `FB_BASE_ADDR` defines.
  - Add a FetcherState_t enum {IDLE, FETCH, DRAINED}.
  - Reuse SramRequest_t / SramResult_t unchanged.
- Sub-module: sync_fifo_fwft.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst, push, pushData, pop, head, count, full, empty.
  - Synchronous active-high reset plus a `flush` input driven by frameStart.

Test Plan:
1. Reset then idle: hold rst 2 cycles, toggle done every other cycle -> oe_n=1, address=0, pixelValid=0, no captures.
2. Frame fill: frameStart; SRAM model returns din=address+0x100; no pops -> exactly 8 captures, head=0x100, readAddr=8. FIFO full; further done cycles capture nothing.
3. Steady scan: pop every 2nd cycle after fill -> pixelData sequence 0x100,0x101,... contiguous, underflow=0 over 1000 pixels.
4. Full with simultaneous push/pop: count=8, done&&pixelReq same cycle -> count stays 8, new tail = next address word.
5. Frame end (FRAME_WORDS=16 override): after 16 captures -> DRAINED, oe_n=1. Popping 17 times -> underflow=1 on the 17th pop.
6. frameStart mid-frame with pixelReq and done asserted -> the next cycle shows count=0, address=BASE_ADDR, pixelValid=0. The following capture is word BASE_ADDR.
